// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - SPI mode-0 byte master with chip select, setup/hold/gap timing and optional receive capture
//
// Parameter:
//   CLK_DIV   sclk cycles per spi_sck half-period (2..255)
// Build option:
//   SPI_MASTER_RXD_EN  defined: capture spi_miso into rxd_data/rxd_flag
//                      undefined: rxd_data=8'h00, rxd_flag=0, spi_miso ignored
// Ports:
//   sclk      in   system clock, rising edge
//   s_rst_n   in   asynchronous active-low reset
//   tx_req    in   single-cycle send request, honoured only in IDLE
//   tx_data   in   [7:0] byte to send, sampled in the accept cycle
//   tx_busy   out  high from the cycle after accept until back in IDLE
//   tx_done   out  one-cycle pulse when chip select releases
//   rxd_data  out  [7:0] last byte captured from spi_miso
//   rxd_flag  out  one-cycle pulse, rxd_data valid
//   spi_cs    out  chip select, active-low
//   spi_sck   out  SPI clock, CPOL=0
//   spi_mosi  out  serial data out, MSB first
//   spi_miso  in   serial data in, MSB first

module spi_master_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] rxd_data,
  output logic       rxd_flag,
  output logic       spi_cs,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] div_cnt;
  logic [3:0]    half_cnt;
  logic [7:0]    tx_sh;
  logic          div_end;
  logic          accept;
  logic          sck_rise;
  logic          sck_fall;

  // Every phase lasts a whole number of divider periods, so one free-running
  // counter (held at zero in IDLE) marks all phase and half-period boundaries.
  assign div_end  = (div_cnt == DIV_LAST);
  assign accept   = (state == IDLE) && tx_req;
  // Even half-periods have sck low; their end is a rising edge, the end of
  // an odd half-period is a falling edge.
  assign sck_rise = (state == SHIFT) && div_end && !half_cnt[0];
  assign sck_fall = (state == SHIFT) && div_end && half_cnt[0];

  // State register
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_req) state_nxt = SETUP;
      SETUP:   if (div_end) state_nxt = SHIFT;
      SHIFT:   if (div_end && (half_cnt == 4'd15)) state_nxt = HOLD;
      HOLD:    if (div_end) state_nxt = GAP;
      GAP:     if (div_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic, decoded from registered state so reset acts immediately
  always_comb begin
    spi_cs   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    tx_busy  = (state != IDLE);
    tx_done  = 1'b0;
    case (state)
      SETUP: begin
        spi_cs   = 1'b0;
        spi_mosi = tx_sh[7];
      end
      SHIFT: begin
        spi_cs   = 1'b0;
        spi_sck  = half_cnt[0];
        spi_mosi = tx_sh[7];
      end
      HOLD: begin
        spi_cs   = 1'b0;
        spi_mosi = tx_sh[7];
      end
      GAP: begin
        // First GAP cycle is the cycle chip select goes high.
        tx_done = (div_cnt == '0);
      end
      default: begin
        spi_cs = 1'b1;
      end
    endcase
  end

  // Divider, half-period counter and transmit shifter
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      div_cnt  <= '0;
      half_cnt <= 4'd0;
      tx_sh    <= 8'h00;
    end else begin
      if ((state == IDLE) || div_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state != SHIFT) begin
        half_cnt <= 4'd0;
      end else if (div_end) begin
        half_cnt <= half_cnt + 4'd1;
      end

      if (accept) begin
        tx_sh <= tx_data;
      end else if (sck_fall && (half_cnt != 4'd15)) begin
        // The 8th falling edge does not shift: bit 0 stays on the line in HOLD.
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
    end
  end

`ifdef SPI_MASTER_RXD_EN
  logic [7:0] rx_sh;
  logic [7:0] rxd_q;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rx_sh <= 8'h00;
      rxd_q <= 8'h00;
    end else begin
      if (sck_rise) begin
        rx_sh <= {rx_sh[6:0], spi_miso};
      end
      // Publish at the HOLD->GAP edge so rxd_flag lines up with tx_done.
      if ((state == HOLD) && div_end) begin
        rxd_q <= rx_sh;
      end
    end
  end

  assign rxd_data = rxd_q;
  assign rxd_flag = tx_done;
`else
  assign rxd_data = 8'h00;
  // spi_miso has no function in this build; the constant AND keeps the port
  // referenced while the output stays tied low.
  assign rxd_flag = 1'b0 & spi_miso;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - directed self-checking bench for spi_master_tx (CLK_DIV=4 and CLK_DIV=2 instances)

module tb_spi_master_tx;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b1;

  logic       req1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       busy1, done1, flag1, cs1, sck1, mosi1, miso1;
  logic [7:0] rxd1;

  logic       req2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       busy2, done2, flag2, cs2, sck2, mosi2;
  logic       miso2 = 1'b0;
  logic [7:0] rxd2;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  spi_master_tx #(.CLK_DIV(4)) dut1 (
    .sclk(sclk), .s_rst_n(rst_n), .tx_req(req1), .tx_data(data1),
    .tx_busy(busy1), .tx_done(done1), .rxd_data(rxd1), .rxd_flag(flag1),
    .spi_cs(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  spi_master_tx #(.CLK_DIV(2)) dut2 (
    .sclk(sclk), .s_rst_n(rst_n), .tx_req(req2), .tx_data(data2),
    .tx_busy(busy2), .tx_done(done2), .rxd_data(rxd2), .rxd_flag(flag2),
    .spi_cs(cs2), .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(miso2)
  );

  // Slave model on dut1: returns slave_byte MSB first, captures mosi, drives an LED from bit 0.
  logic [7:0] slave_byte = 8'hA5;
  logic [7:0] s_rx = 8'h00;
  logic       led;
  int         rise_total = 0;
  int         cs_base = 0;
  int         s_idx;

  always @(posedge sck1) begin
    rise_total <= rise_total + 1;
    s_rx       <= {s_rx[6:0], mosi1};
  end
  always @(negedge cs1) cs_base <= rise_total;
  always @(posedge cs1) led <= s_rx[0];

  assign s_idx = rise_total - cs_base;
  assign miso1 = (s_idx >= 0 && s_idx < 8) ? slave_byte[3'(7 - s_idx)] : 1'b0;

  typedef struct {
    int         done_at, done_cnt, cs_first, cs_last, idle_at;
    int         r1, r2, nr, viol, flag_cnt, flag_at;
    logic [7:0] mb, rxv;
  } res_t;
  res_t res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller raises tx_req at a negedge (cycle T); this observes cycles T+1..T+n.
  task automatic run(input int n, input bit sel, input int inj_at);
    logic cs, sck, mosi, done, busy, flag, prev_sck;
    logic [7:0] rxd;
    res = '{default: 0};
    prev_sck = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge sclk);
      if (k == 1) begin
        req1 = 1'b0;
        req2 = 1'b0;
      end
      if (inj_at != 0 && k == inj_at) begin
        req1  = 1'b1;
        data1 = 8'hFF;
      end
      if (inj_at != 0 && k == inj_at + 1) begin
        req1  = 1'b0;
        data1 = 8'h00;
      end
      cs   = sel ? cs2   : cs1;
      sck  = sel ? sck2  : sck1;
      mosi = sel ? mosi2 : mosi1;
      done = sel ? done2 : done1;
      busy = sel ? busy2 : busy1;
      flag = sel ? flag2 : flag1;
      rxd  = sel ? rxd2  : rxd1;
      if (done) begin
        res.done_cnt++;
        if (res.done_at == 0) res.done_at = k;
      end
      if (!cs) begin
        if (res.cs_first == 0) res.cs_first = k;
        res.cs_last = k;
      end
      if (!busy && res.idle_at == 0) res.idle_at = k;
      if (sck && !prev_sck) begin
        res.nr++;
        if (res.nr == 1) res.r1 = k;
        if (res.nr == 2) res.r2 = k;
        res.mb = {res.mb[6:0], mosi};
      end
      prev_sck = sck;
      if (cs && (sck || mosi)) res.viol++;
      if (flag) begin
        res.flag_cnt++;
        res.flag_at = k;
        res.rxv = rxd;
      end
    end
  endtask

  task automatic chk_rx(input string tag, input logic [7:0] exp_byte, input int exp_at, input logic [7:0] rxd_now);
`ifdef SPI_MASTER_RXD_EN
    chk({tag, "_flag_cnt"}, res.flag_cnt, 1);
    chk({tag, "_flag_at"}, res.flag_at, exp_at);
    chk({tag, "_rxd"}, res.rxv, exp_byte);
    chk({tag, "_rxd_hold"}, rxd_now, exp_byte);
`else
    chk({tag, "_flag_cnt"}, res.flag_cnt, 0);
    chk({tag, "_rxd"}, rxd_now, 8'h00);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nwait;
    int base;
    int leak;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cs", cs1, 1'b1);
    chk("rst_sck", sck1, 1'b0);
    chk("rst_mosi", mosi1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_flag", flag1, 1'b0);
    chk("rst_rxd", rxd1, 8'h00);
    @(negedge sclk);
    rst_n = 1'b1;

    // Single byte 8'h02, slave returns 8'hA5
    @(negedge sclk);
    req1 = 1'b1; data1 = 8'h02;
    run(80, 1'b0, 0);
    chk("t1_cs_first", res.cs_first, 1);
    chk("t1_cs_last", res.cs_last, 72);
    chk("t1_done_at", res.done_at, 73);
    chk("t1_done_cnt", res.done_cnt, 1);
    chk("t1_idle_at", res.idle_at, 77);
    chk("t1_rises", res.nr, 8);
    chk("t1_first_rise", res.r1, 9);
    chk("t1_sck_period", res.r2 - res.r1, 8);
    chk("t1_mosi_byte", res.mb, 8'h02);
    chk("t1_slave_rx", s_rx, 8'h02);
    chk("t1_idle_lines", res.viol, 0);
    chk_rx("t1", 8'hA5, 73, rxd1);

    // Request while busy at T+10 with 8'hFF: ignored, not queued
    @(negedge sclk);
    req1 = 1'b1; data1 = 8'h3C;
    run(90, 1'b0, 10);
    chk("t2_rises", res.nr, 8);
    chk("t2_mosi_byte", res.mb, 8'h3C);
    chk("t2_slave_rx", s_rx, 8'h3C);
    chk("t2_done_at", res.done_at, 73);
    chk("t2_done_cnt", res.done_cnt, 1);
    chk("t2_cs_last", res.cs_last, 72);
    chk("t2_idle_lines", res.viol, 0);

    // Back-to-back 8'h01 then 8'h08, second request at T+77
    @(negedge sclk);
    req1 = 1'b1; data1 = 8'h01;
    run(77, 1'b0, 0);
    chk("t3a_cs_last", res.cs_last, 72);
    chk("t3a_done_at", res.done_at, 73);
    chk("t3a_idle_at", res.idle_at, 77);
    chk("t3a_slave_rx", s_rx, 8'h01);
    chk("t3a_led", led, 1'b1);
    req1 = 1'b1; data1 = 8'h08;
    run(80, 1'b0, 0);
    chk("t3b_cs_first", res.cs_first, 1);
    chk("t3b_done_at", res.done_at, 73);
    chk("t3b_slave_rx", s_rx, 8'h08);
    chk("t3b_led", led, 1'b0);
    chk_rx("t3b", 8'hA5, 73, rxd1);

    // Reset after the 4th sck rising edge, then 8'h03 right after release
    @(negedge sclk);
    req1 = 1'b1; data1 = 8'hC3;
    base = rise_total;
    nwait = 0;
    leak = 0;
    while ((rise_total - base) < 4 && nwait < 100) begin
      @(negedge sclk);
      req1 = 1'b0;
      nwait++;
      leak += int'(done1) + int'(flag1);
    end
    chk("t4_wait_rise4", (nwait < 100), 1'b1);
    chk("t4_pre_sck", sck1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_cs", cs1, 1'b1);
    chk("t4_rst_sck", sck1, 1'b0);
    chk("t4_rst_mosi", mosi1, 1'b0);
    chk("t4_rst_busy", busy1, 1'b0);
    chk("t4_rst_rxd", rxd1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      leak += int'(done1) + int'(flag1);
    end
    chk("t4_no_pulse", leak, 0);
    rst_n = 1'b1;
    req1 = 1'b1; data1 = 8'h03;
    run(80, 1'b0, 0);
    chk("t4_cs_first", res.cs_first, 1);
    chk("t4_done_at", res.done_at, 73);
    chk("t4_done_cnt", res.done_cnt, 1);
    chk("t4_mosi_byte", res.mb, 8'h03);
    chk("t4_slave_rx", s_rx, 8'h03);

    // CLK_DIV=2 instance with 8'h5A
    @(negedge sclk);
    req2 = 1'b1; data2 = 8'h5A;
    run(45, 1'b1, 0);
    chk("t5_first_rise", res.r1, 5);
    chk("t5_sck_period", res.r2 - res.r1, 4);
    chk("t5_rises", res.nr, 8);
    chk("t5_mosi_byte", res.mb, 8'h5A);
    chk("t5_cs_last", res.cs_last, 36);
    chk("t5_done_at", res.done_at, 37);
    chk("t5_idle_at", res.idle_at, 39);
    chk("t5_idle_lines", res.viol, 0);
    chk_rx("t5", 8'h00, 37, rxd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
